// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin encoding, coin values and the
// change dispenser's state encoding.
package vend_pkg;

  // Coin codes on the actuator/collector buses.
  typedef enum logic [1:0] {
    COIN25  = 2'b00,
    COIN50  = 2'b01,
    COIN100 = 2'b10,
    NOCOIN  = 2'b11
  } coin_e;

  // Coin values in 25-paise units.
  localparam int unsigned COIN25_UNITS  = 1;
  localparam int unsigned COIN50_UNITS  = 2;
  localparam int unsigned COIN100_UNITS = 4;

  // Width of the acknowledge timer (timeouts up to 255 cycles).
  localparam int unsigned ACK_TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DISPENSE,
    ST_DONE,
    ST_ERROR
  } disp_state_e;

  // Value of a coin code in 25p units; NOCOIN is worth nothing.
  function automatic int unsigned coin_units(coin_e c);
    case (c)
      COIN25:  return COIN25_UNITS;
      COIN50:  return COIN50_UNITS;
      COIN100: return COIN100_UNITS;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_ack_timer.sv
// Loadable saturating counter that measures how long a presented coin has
// waited for its acknowledge. expire_o flags the enabled cycle whose
// increment reaches LIMIT, so the owner can leave on that same edge.
module ack_timer #(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  // Counter: clear beats load beats increment; holds once LIMIT is reached.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != W'(LIMIT))) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expire_o = en_i && (count_q >= W'(LIMIT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount (in 25p units) out as a greedy sequence of
// coins over a valid/ack handshake to the coin-release actuator.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [AMT_W-1:0] amount_in,
  input  logic [2:0]       empty_in,
  input  logic             coin_ack_in,
  input  logic             clear_in,
  output logic [1:0]       coin_out,
  output logic             coin_valid_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out,
  output logic [AMT_W-1:0] remaining_out
);

  localparam logic [AMT_W-1:0] V25  = AMT_W'(COIN25_UNITS);
  localparam logic [AMT_W-1:0] V50  = AMT_W'(COIN50_UNITS);
  localparam logic [AMT_W-1:0] V100 = AMT_W'(COIN100_UNITS);

  disp_state_e      state_q;
  coin_e            coin_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [AMT_W-1:0] rem_q;

  coin_e            sel_coin;
  logic             sel_ok;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_expire;

  // Greedy pick: largest stocked coin that does not exceed what is owed.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_coin = NOCOIN;
    sel_ok   = 1'b0;
    if (!empty_in[2] && (rem_q >= V100)) begin
      sel_coin = COIN100;
      sel_ok   = 1'b1;
    end else if (!empty_in[1] && (rem_q >= V50)) begin
      sel_coin = COIN50;
      sel_ok   = 1'b1;
    end else if (!empty_in[0] && (rem_q >= V25)) begin
      sel_coin = COIN25;
      sel_ok   = 1'b1;
    end
  end

  // The timer restarts whenever a coin is loaded; an ack on the expiry edge
  // suppresses the count so the handshake wins.
  assign tmr_clr = (state_q == ST_SELECT);
  assign tmr_en  = (state_q == ST_DISPENSE) && !coin_ack_in;

  ack_timer #(
    .LIMIT (ACK_TIMEOUT),
    .W     (ACK_TMR_W)
  ) u_ack_timer (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (tmr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  // Payout FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      coin_q  <= NOCOIN;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            rem_q   <= amount_in;
            busy_q  <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (sel_ok) begin
            coin_q  <= sel_coin;
            valid_q <= 1'b1;
            state_q <= ST_DISPENSE;
          end else begin
            coin_q  <= NOCOIN;
            err_q   <= 1'b1;
            state_q <= ST_ERROR;
          end
        end
        ST_DISPENSE: begin
          if (coin_ack_in) begin
            rem_q   <= rem_q - AMT_W'(coin_units(coin_q));
            coin_q  <= NOCOIN;
            valid_q <= 1'b0;
            state_q <= ST_SELECT;
          end else if (tmr_expire) begin
            coin_q  <= NOCOIN;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_ERROR;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          if (clear_in) begin
            rem_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign coin_out       = coin_q;
  assign coin_valid_out = valid_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign err_out        = err_q;
  assign remaining_out  = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a greedy payout model pushes the
// expected coin/done/error events into a scoreboard, and a monitor pops and
// compares them as the DUT presents them.
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int EV_COIN = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             start_in;
  logic [AMT_W-1:0] amount_in;
  logic [2:0]       empty_in;
  logic             coin_ack_in;
  logic             clear_in;
  logic [1:0]       coin_out;
  logic             coin_valid_out;
  logic             busy_out;
  logic             done_out;
  logic             err_out;
  logic [AMT_W-1:0] remaining_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] sb[$];

  // Actuator behaviour controls.
  bit ack_en    = 1'b1;
  int ack_delay = 0;

  change_dispenser #(
    .AMT_W       (AMT_W),
    .ACK_TIMEOUT (15)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start_in       (start_in),
    .amount_in      (amount_in),
    .empty_in       (empty_in),
    .coin_ack_in    (coin_ack_in),
    .clear_in       (clear_in),
    .coin_out       (coin_out),
    .coin_valid_out (coin_valid_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .err_out        (err_out),
    .remaining_out  (remaining_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] enc(int kind, logic [1:0] coin, int rem);
    return (32'(kind) << 8) | (32'(coin) << 4) | 32'(rem);
  endfunction

  // Reference model: pay amt greedily from the stocked denominations. If
  // stall_idx >= 0, that coin is never acknowledged and the payout times out.
  task automatic expect_payout(input int amt, input logic [2:0] empty, input int stall_idx);
    int          values[3];
    logic [1:0]  codes[3];
    int          rem;
    int          idx;
    int          pick;
    values = '{4, 2, 1};
    codes  = '{2'b10, 2'b01, 2'b00};
    rem = amt;
    idx = 0;
    while (rem > 0) begin
      pick = -1;
      for (int i = 0; i < 3; i++)
        if (pick < 0 && !empty[2-i] && values[i] <= rem) pick = i;
      if (pick < 0) begin
        sb.push_back(enc(EV_ERR, 2'b11, rem));
        return;
      end
      sb.push_back(enc(EV_COIN, codes[pick], rem));
      if (idx == stall_idx) begin
        sb.push_back(enc(EV_ERR, 2'b11, rem));
        return;
      end
      rem -= values[pick];
      idx++;
    end
    sb.push_back(enc(EV_DONE, 2'b11, 0));
  endtask

  task automatic sb_compare(input logic [31:0] ev);
    if (sb.size() == 0) check("unexpected event", ev, 32'hFFFF_FFFF);
    else check("event", ev, sb.pop_front());
  endtask

  // Monitor: turns DUT output activity into events and checks coin stability.
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;
  logic [1:0] held_coin  = 2'b11;
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (coin_valid_out && !prev_valid) begin
        sb_compare(enc(EV_COIN, coin_out, int'(remaining_out)));
        held_coin = coin_out;
      end else if (coin_valid_out) begin
        check("coin held stable", 32'(coin_out), 32'(held_coin));
      end
      if (done_out) sb_compare(enc(EV_DONE, 2'b11, int'(remaining_out)));
      if (err_out && !prev_err) sb_compare(enc(EV_ERR, 2'b11, int'(remaining_out)));
      prev_valid = coin_valid_out;
      prev_err   = err_out;
    end
  end

  // Actuator: acknowledges a presented coin after ack_delay idle cycles.
  initial begin
    int wait_cnt;
    coin_ack_in = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clock);
      coin_ack_in = 1'b0;
      if (ack_en && coin_valid_out === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          coin_ack_in = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic start(input int amt);
    @(negedge clock);
    start_in  = 1'b1;
    amount_in = AMT_W'(amt);
    @(negedge clock);
    start_in  = 1'b0;
    amount_in = AMT_W'($urandom_range(0, 15));
  endtask

  task automatic settle();
    int i;
    for (i = 0; i < 300; i++) begin
      if (sb.size() == 0 && (!busy_out || err_out)) break;
      @(negedge clock);
    end
    check("all expected events seen", 32'(sb.size()), 32'd0);
    @(negedge clock);
  endtask

  task automatic clear_error();
    @(negedge clock);
    clear_in = 1'b1;
    @(negedge clock);
    clear_in = 1'b0;
    check("busy after clear", 32'(busy_out), 32'd0);
    check("err after clear", 32'(err_out), 32'd0);
    check("remaining after clear", 32'(remaining_out), 32'd0);
  endtask

  initial begin
    int cnt;
    int amt;
    logic [2:0] emp;
    reset = 1'b0;
    start_in = 1'b0;
    amount_in = '0;
    empty_in = 3'b000;
    clear_in = 1'b0;

    #12;
    check("reset coin_out", 32'(coin_out), 32'd3);
    check("reset valid", 32'(coin_valid_out), 32'd0);
    check("reset busy", 32'(busy_out), 32'd0);
    check("reset done", 32'(done_out), 32'd0);
    check("reset err", 32'(err_out), 32'd0);
    check("reset remaining", 32'(remaining_out), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Amount 7, all tubes stocked, ack one cycle after valid.
    ack_delay = 0;
    expect_payout(7, 3'b000, -1);
    start(7);
    check("valid one edge after start", 32'(coin_valid_out), 32'd0);
    @(negedge clock);
    check("valid two edges after start", 32'(coin_valid_out), 32'd1);
    settle();

    // Amount 4 with the 1 Rs tube empty, then with 1 Rs and 50p empty.
    ack_delay = 1;
    empty_in = 3'b100;
    expect_payout(4, empty_in, -1);
    start(4);
    settle();
    empty_in = 3'b110;
    expect_payout(4, empty_in, -1);
    start(4);
    settle();

    // Amount 1 with the 25p tube empty: error without any coin.
    empty_in = 3'b001;
    expect_payout(1, empty_in, -1);
    start(1);
    settle();
    check("err on no change", 32'(err_out), 32'd1);
    clear_error();
    empty_in = 3'b000;

    // Amount 2 with the ack withheld: valid for 15 cycles, then timeout.
    ack_en = 1'b0;
    expect_payout(2, 3'b000, 0);
    start(2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (err_out) break;
      if (coin_valid_out) cnt++;
      @(negedge clock);
    end
    check("valid cycles before timeout", 32'(cnt), 32'd15);
    settle();
    clear_error();

    // Ack arriving on the expiry edge completes the coin.
    ack_en = 1'b1;
    ack_delay = 14;
    expect_payout(2, 3'b000, -1);
    start(2);
    settle();
    check("no error when ack meets expiry", 32'(err_out), 32'd0);

    // Amount 0: done two edges after start, no coin.
    ack_delay = 0;
    expect_payout(0, 3'b000, -1);
    @(negedge clock);
    start_in = 1'b1;
    amount_in = '0;
    @(negedge clock);
    start_in = 1'b0;
    check("zero amount done after 1 edge", 32'(done_out), 32'd0);
    @(negedge clock);
    check("zero amount done after 2 edges", 32'(done_out), 32'd1);
    settle();

    // Second start while paying 5 is ignored.
    ack_delay = 2;
    expect_payout(5, 3'b000, -1);
    start(5);
    for (int i = 0; i < 20 && !coin_valid_out; i++) @(negedge clock);
    start_in = 1'b1;
    amount_in = 4'd7;
    @(negedge clock);
    start_in = 1'b0;
    settle();

    // Asynchronous reset in the middle of a dispense.
    ack_en = 1'b0;
    expect_payout(5, 3'b000, 0);
    start(5);
    for (int i = 0; i < 20 && !coin_valid_out; i++) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("valid drops on async reset", 32'(coin_valid_out), 32'd0);
    check("busy drops on async reset", 32'(busy_out), 32'd0);
    check("remaining cleared by reset", 32'(remaining_out), 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    ack_en = 1'b1;
    ack_delay = 0;
    expect_payout(3, 3'b000, -1);
    start(3);
    settle();

    // Randomized payouts against the model.
    for (int t = 0; t < 25; t++) begin
      amt = $urandom_range(0, 15);
      emp = 3'($urandom_range(0, 7));
      ack_delay = $urandom_range(0, 3);
      empty_in = emp;
      expect_payout(amt, emp, -1);
      start(amt);
      settle();
      if (err_out) clear_error();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out change for the vending machine, in the opposite direction to the coin collector. It takes an amount in 25-paise units and emits a sequence of coins to the coin-release actuator over a valid/ack handshake. Coin choice is greedy: the largest non-empty denomination that does not exceed the remaining amount. It sits between the vend controller (start/amount/done) and the actuator (coin/valid/ack), and reports an error when change cannot be made or the actuator stops responding.

Parameters:
AMT_W, 4, width of amount in 25p units (max 3.75 Rs at default)
ACK_TIMEOUT, 15, cycles coin_valid_out may stay high without ack before error (1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start_in  input  1  request payout of amount_in; sampled only in IDLE
amount_in  input  AMT_W  change amount in 25p units
empty_in  input  3  tube-empty flags: bit0 = 25p, bit1 = 50p, bit2 = 1 Rs
coin_ack_in  input  1  actuator has released the presented coin
clear_in  input  1  leave ERROR
coin_out  output  2  coin code: 00 = 25p, 01 = 50p, 10 = 1 Rs, 11 = no coin
coin_valid_out  output  1  coin_out is valid and held stable until acked
busy_out  output  1  payout in progress (any state except IDLE)
done_out  output  1  one-cycle pulse when payout is complete
err_out  output  1  high while in ERROR
remaining_out  output  AMT_W  amount still owed

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - coin_out=11, coin_valid_out=0, busy_out=0, done_out=0, err_out=0, remaining_out=0, timer=0.
- All outputs are registered.
- Coin values: 25p=1, 50p=2, 1 Rs=4 units.
- States: IDLE, SELECT, DISPENSE, DONE, ERROR.
- IDLE:
  - start_in=1 at an edge: latch remaining=amount_in, go to SELECT.
  - start_in=0: stay.
- SELECT, evaluated against remaining and empty_in as sampled that cycle:
  - remaining=0: go to DONE.
  - Otherwise pick the first of 1 Rs, 50p, 25p whose value <= remaining and whose empty bit is 0. Load coin_out, set coin_valid_out=1, clear timer, go to DISPENSE.
  - No candidate: go to ERROR with coin_out=11.
- DISPENSE:
  - coin_out and coin_valid_out are held stable.
  - coin_ack_in=1 at an edge: coin_valid_out=0, coin_out=11, remaining -= coin value, go to SELECT.
  - No ack: timer increments. If timer reaches ACK_TIMEOUT, go to ERROR and drop coin_valid_out, with remaining unchanged.
- DONE: done_out=1 for exactly this one cycle, then IDLE.
- ERROR:
  - err_out=1, busy_out=1, coin_valid_out=0.
  - clear_in=1: go to IDLE with remaining cleared.
  - start_in is ignored.
- Latency:
  - Start edge to first coin_valid_out=1: 2 edges.
  - Ack edge to next coin_valid_out=1: 2 edges.
  - Last ack edge to done_out=1: 2 edges.
- Boundaries and simultaneous events:
  - start_in with amount_in=0: IDLE, SELECT, DONE. A done pulse is issued and no coins are paid.
  - start_in while not IDLE: ignored. amount_in is not re-latched.
  - coin_ack_in outside DISPENSE: ignored.
  - empty_in changing during DISPENSE: no effect on the presented coin; it is re-evaluated at the next SELECT.
  - Ack on the same edge the timer would expire: the ack wins.
  - clear_in outside ERROR: ignored.
  - Reset asserted mid-payout: everything is abandoned immediately and asynchronously. coin_valid_out drops with no handshake completion.
- remaining never underflows, because the chosen coin value is always <= remaining.

Decomposition:
- Shared package (vend_pkg):
  - Coin code constants COIN25, COIN50, COIN100, NOCOIN (same encoding as the collector).
  - Coin unit values.
  - State encoding for this block.
- One sub-module: ack_timer. It is a loadable saturating counter with clear/enable and an expire flag at ACK_TIMEOUT, instantiated once.
- Greedy selection stays inline as combinational logic.

Test Plan:
- Amount 7, empty_in=000, ack 1 cycle after each valid -> coins 10, 01, 00 in order; remaining_out goes 7, 3, 1, 0; done_out pulses once; 3 handshakes.
- Amount 4, empty_in=100 -> coins 01, 01, then done. Amount 4, empty_in=110 -> 00 x4, then done.
- Amount 1, empty_in=001 -> ERROR with no coin_valid_out. Then clear_in=1 -> IDLE with busy_out=0.
- Amount 2, ack withheld -> coin_valid_out high for 15 cycles, then err_out=1 and remaining_out=2. Also check that an ack on the expiry edge completes the coin instead.
- Amount 0 -> done_out pulse 2 edges after start, with coin_valid_out never asserted. A second start_in while busy on an amount-5 payout is ignored, with exactly coins 10, 00 issued.
- Async reset (reset=0) mid-DISPENSE, between edges -> coin_valid_out=0 and busy_out=0 immediately. After release, a new start of amount 3 gives 01, 00.
